// File: rtl/led_blinker.sv
// Free-running LED pattern generator: period counter, four display modes,
// 16-level PWM brightness and a once-per-period tick.
module led_blinker #(
  parameter int CNT_WIDTH = 27
) (
  input  logic       clk_128M,
  input  logic       rst_128M,
  input  logic [1:0] mode,
  input  logic [3:0] duty,
  output logic       led,
  output logic       tick
);

  localparam int PWM_WIDTH = 4;
  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ModeOff       = 2'd0,
    ModeOn        = 2'd1,
    ModeBlink     = 2'd2,
    ModeHeartbeat = 2'd3
  } mode_e;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 led_q, led_d;
  logic                 tick_q, tick_d;
  logic                 pwm_on;
  logic                 pat;
  logic [3:0]           hbPhase;
  mode_e                modeSel;

  // All decoding looks at the pre-increment count, so outputs lag it by one.
  always_comb begin
    cnt_d   = cnt_q + CntOne;
    modeSel = mode_e'(mode);
    hbPhase = cnt_q[CNT_WIDTH-1 -: 4];
    pwm_on  = (cnt_q[PWM_WIDTH-1:0] <= duty);
    pat     = 1'b0;
    case (modeSel)
      ModeOff:       pat = 1'b0;
      ModeOn:        pat = 1'b1;
      ModeBlink:     pat = cnt_q[CNT_WIDTH-1];
      ModeHeartbeat: pat = (hbPhase == 4'h0) || (hbPhase == 4'h2);
      default:       pat = 1'b0;
    endcase
    led_d  = pat & pwm_on;
    tick_d = &cnt_q;
  end

  always_ff @(posedge clk_128M or posedge rst_128M) begin
    if (rst_128M) begin
      cnt_q  <= '0;
      led_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      tick_q <= tick_d;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_blinker.sv
// Directed bench for led_blinker with CNT_WIDTH = 8 (period 256 cycles).
module tb_led_blinker;

  logic       clk_128M;
  logic       rst_128M;
  logic [1:0] mode;
  logic [3:0] duty;
  logic       led;
  logic       tick;

  int compared;
  int mismatched;
  int edges;
  int dec;
  int highs;
  int ticks;
  int lastTickEdge;

  led_blinker #(.CNT_WIDTH(8)) dut (
    .clk_128M (clk_128M),
    .rst_128M (rst_128M),
    .mode     (mode),
    .duty     (duty),
    .led      (led),
    .tick     (tick)
  );

  initial clk_128M = 1'b0;
  always #5 clk_128M = ~clk_128M;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One rising edge; dec is the counter value the outputs now reflect.
  task automatic applyStimulus();
    @(posedge clk_128M);
    #1;
    edges++;
    dec = (edges - 1) % 256;
    checkOutput("tick", {31'd0, tick}, {31'd0, (dec == 255)});
    if (tick === 1'b1) begin
      ticks++;
      if (lastTickEdge > 0)
        checkOutput("tickSpacing", edges - lastTickEdge, 256);
      lastTickEdge = edges;
    end
  endtask

  task automatic releaseReset();
    @(negedge clk_128M);
    rst_128M = 1'b0;
    edges = 0;
    lastTickEdge = 0;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    edges = 0;
    ticks = 0;
    lastTickEdge = 0;
    rst_128M = 1'b1;
    mode = 2'd1;
    duty = 4'd15;
    repeat (2) @(posedge clk_128M);
    #1;
    checkOutput("resetLed", {31'd0, led}, 32'd0);
    checkOutput("resetTick", {31'd0, tick}, 32'd0);

    // Steady on, first period; first tick lands on edge 256.
    releaseReset();
    for (int i = 0; i < 256; i++) begin
      applyStimulus();
      checkOutput("onLed", {31'd0, led}, 32'd1);
    end
    checkOutput("firstTickEdge", lastTickEdge, 256);

    // Asynchronous reset mid-cycle while led and tick are both high.
    #2 rst_128M = 1'b1;
    #1;
    checkOutput("asyncRstLed", {31'd0, led}, 32'd0);
    checkOutput("asyncRstTick", {31'd0, tick}, 32'd0);
    @(posedge clk_128M);
    #1;
    checkOutput("heldRstLed", {31'd0, led}, 32'd0);

    // Blink: high exactly for the upper half-period.
    mode = 2'd2;
    duty = 4'd15;
    ticks = 0;
    releaseReset();
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus();
      checkOutput("blinkLed", {31'd0, led}, {31'd0, (dec >= 128)});
      if (led === 1'b1) highs++;
    end
    checkOutput("blinkHighs", highs, 128);
    checkOutput("blinkTicks", ticks, 1);
    checkOutput("blinkTickEdge", lastTickEdge, 256);

    // Heartbeat: two 16-cycle pulses at the start of each period.
    mode = 2'd3;
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus();
      checkOutput("hbLed", {31'd0, led},
                  {31'd0, ((dec < 16) || (dec >= 32 && dec < 48))});
      if (led === 1'b1) highs++;
    end
    checkOutput("hbHighs", highs, 32);

    // PWM at minimum brightness.
    mode = 2'd1;
    duty = 4'd0;
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus();
      checkOutput("pwm0Led", {31'd0, led}, {31'd0, ((dec % 16) == 0)});
      if (led === 1'b1) highs++;
    end
    checkOutput("pwm0Highs", highs, 16);

    // PWM at duty 7: half brightness.
    duty = 4'd7;
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus();
      checkOutput("pwm7Led", {31'd0, led}, {31'd0, ((dec % 16) <= 7)});
      if (led === 1'b1) highs++;
    end
    checkOutput("pwm7Highs", highs, 128);

    // Off for a full period; tick keeps running.
    mode = 2'd0;
    duty = 4'd15;
    ticks = 0;
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus();
      if (led === 1'b1) highs++;
    end
    checkOutput("offHighs", highs, 0);
    checkOutput("offTicks", ticks, 1);

    // Switch to steady on while the counter holds 100.
    for (int i = 0; i < 100; i++) applyStimulus();
    checkOutput("preSwitchDec", dec, 99);
    checkOutput("preSwitchLed", {31'd0, led}, 32'd0);
    mode = 2'd1;
    applyStimulus();
    checkOutput("switchDec", dec, 100);
    checkOutput("switchLed", {31'd0, led}, 32'd1);
    for (int i = 0; i < 155; i++) begin
      applyStimulus();
      checkOutput("postSwitchLed", {31'd0, led}, 32'd1);
    end

    // Three more periods to confirm wrap and tick spacing.
    mode = 2'd2;
    ticks = 0;
    for (int i = 0; i < 768; i++) applyStimulus();
    checkOutput("wrapTicks", ticks, 3);
    checkOutput("wrapLastTickEdge", lastTickEdge, edges);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/led_blinker.md
# led_blinker

Free-running LED pattern generator that turns a fast system clock into a human-visible indicator. It drives one board LED, and optionally a test pin, in the alchitry top level. It supports four display modes and 16-level PWM brightness, and emits a once-per-period tick. Several instances may run side by side, one per clock domain, as clock-alive indicators.

## Interface
Parameters:
- `CNT_WIDTH`, default 27: width of the period counter.
  - Pattern period is 2^CNT_WIDTH cycles (about 1.05 s at 128 MHz).
  - Legal range is 8..32.
- `PWM_WIDTH`, fixed at 4: PWM resolution in bits. It is a localparam and not overridable.

Ports:
- `clk_128M`, input, 1: the single clock. All logic is on its rising edge.
- `rst_128M`, input, 1: reset, asynchronous and active-high.
- `mode`, input, 2: display mode. 0 = off, 1 = steady on, 2 = blink, 3 = heartbeat.
- `duty`, input, 4: brightness. 15 = full on, 0 = 1/16 on.
- `led`, output, 1: registered LED drive, active-high.
- `tick`, output, 1: one-cycle pulse once per period.

## Operation
Period counter `cnt`:
- CNT_WIDTH bits, unsigned.
- Increments by 1 every cycle.
- Wraps from all-ones to 0 with no stall or saturation.

PWM gate `pwm_on`:
- `pwm_on` = (`cnt[3:0]` <= `duty`), an unsigned compare.
- `duty` = 15 makes the gate always true.
- `duty` = 0 makes it true on 1 of every 16 cycles.

Pattern term `pat`, by mode:
- Mode 0: `pat` = 0.
- Mode 1: `pat` = 1.
- Mode 2: `pat` = `cnt[CNT_WIDTH-1]`, a 50% square wave that is high in the upper half-period.
- Mode 3: `pat` = 1 when `cnt[CNT_WIDTH-1:CNT_WIDTH-4]` equals 4'h0 or 4'h2. This gives two pulses of 2^(CNT_WIDTH-4) cycles each, separated by an equal gap, at the start of each period.

Outputs:
- Next `led` = `pat` AND `pwm_on`, evaluated on the current (pre-increment) `cnt`.
- Next `tick` = (`cnt` == all-ones).

Inputs:
- `mode` and `duty` are sampled combinationally each cycle with no synchronizer; callers drive them from the `clk_128M` domain.
- A change takes effect at the next edge. The counter is not restarted.

No other state, no handshake, no backpressure.

## Timing
- Reset asserted (asynchronous): `cnt` = 0, `led` = 0, `tick` = 0 immediately, held while `rst_128M` is high.
- After reset release:
  - The first rising edge evaluates `cnt` = 0 and then sets `cnt` = 1.
  - So `led` reflects `cnt` = 0 after edge 1.
- Latency: `led` and `tick` lag the `cnt` value they decode by exactly 1 cycle.
- `tick`:
  - High for exactly 1 cycle per 2^CNT_WIDTH cycles.
  - That cycle coincides with `cnt` = 0 after wrap.
  - The first tick occurs 2^CNT_WIDTH edges after reset release.
- Mode change mid-period: the new pattern applies from the current `cnt` phase, with no glitch beyond one registered transition.
- Reset mid-period:
  - Outputs clear asynchronously.
  - On release, `cnt` restarts from 0 and phase is lost.
- Minimum CNT_WIDTH of 8 guarantees the PWM bits and the heartbeat decode bits do not overlap.

## Test plan
Benches run with CNT_WIDTH = 8 (period 256).
- Reset:
  - Stimulus: assert `rst_128M` asynchronously mid-cycle with mode = 1 and duty = 15.
  - Required: `led` = 0 and `tick` = 0 without waiting for an edge.
  - After release: `led` = 1 after the first edge.
- Blink:
  - Stimulus: mode = 2, duty = 15, one full period.
  - Required: `led` low for cycles decoding `cnt` 0..127 and high for 128..255, i.e. exactly 128 high cycles per 256.
  - Required: `tick` pulses once per 256 cycles.
- Heartbeat:
  - Stimulus: mode = 3, duty = 15.
  - Required: `led` high exactly for `cnt` 0..15 and 32..47; 32 high cycles per period.
- PWM:
  - Stimulus: mode = 1, duty = 0.
  - Required: `led` high 1 cycle of every 16, when `cnt[3:0]` == 0.
  - Stimulus: duty = 7.
  - Required: 8 of every 16 cycles high.
- Off and mode switch:
  - Stimulus: mode = 0 for a full period.
  - Required: `led` never high, while `tick` still pulses every 256 cycles.
  - Stimulus: switch to mode = 1 at `cnt` = 100.
  - Required: `led` = 1 one cycle later.
- Wrap:
  - Stimulus: run 3 periods.
  - Required: `tick` spacing is exactly 256 cycles; the first tick arrives 256 edges after reset release.
